// File: rtl/pacman_pkg.sv
// Shared types for the pacman sprite animator: animation states, orientation codes, colours.
// The colour macros are guarded so that a project-wide constants.vh can supply them instead.
`ifndef TRNS
`define TRNS 8'h00
`endif
`ifndef YELLOW
`define YELLOW 8'hFC
`endif
`ifndef WHITE
`define WHITE 8'hFF
`endif

package pacman_pkg;

  typedef enum logic [2:0] {
    OPEN   = 3'd0,
    HALF_C = 3'd1,
    CLOSED = 3'd2,
    HALF_O = 3'd3,
    DYING  = 3'd4,
    DEAD   = 3'd5
  } anim_state_t;

  localparam logic [1:0] UP    = 2'b00;
  localparam logic [1:0] DOWN  = 2'b01;
  localparam logic [1:0] LEFT  = 2'b10;
  localparam logic [1:0] RIGHT = 2'b11;

  function automatic logic is_mouth_state(input anim_state_t s);
    return s inside {OPEN, HALF_C, CLOSED, HALF_O};
  endfunction

endpackage

// File: rtl/pacman_sprite_rom.sv
// Combinational sprite lookup: (state, death index, row, col) -> lit bit.
// Bitmaps are derived geometrically, so they scale to any power-of-two SPRITE_SIZE.
module pacman_sprite_rom
  import pacman_pkg::*;
#(
  parameter int SPRITE_SIZE = 16,
  parameter int DEATH_STEPS = 8,
  localparam int AW = $clog2(SPRITE_SIZE)
) (
  input  anim_state_t     state,
  input  logic [3:0]      death_idx,
  input  logic [AW-1:0]   row,
  input  logic [AW-1:0]   col,
  output logic            lit
);

  localparam int N = SPRITE_SIZE;

  int   dx;
  int   dy;
  int   ady;
  logic in_disc;
  logic open_mouth;
  logic half_mouth;
  logic death_mouth;

  // Coordinates are doubled so the disc centre sits on an integer point.
  // The death wedge widens from the open mouth to a full half-disc as the index grows.
  always_comb begin
    dx          = 2 * int'(col) + 1 - N;
    dy          = 2 * int'(row) + 1 - N;
    ady         = (dy < 0) ? -dy : dy;
    in_disc     = (dx * dx + dy * dy) <= N * N;
    open_mouth  = (dx > 0) && (ady <= dx);
    half_mouth  = (dx > 0) && (2 * ady <= dx);
    death_mouth = (ady * (DEATH_STEPS - 1 - int'(death_idx))) < (dx * (DEATH_STEPS - 1));
    lit         = 1'b0;
    case (state)
      OPEN:           lit = in_disc && !open_mouth;
      HALF_C, HALF_O: lit = in_disc && !half_mouth;
      CLOSED:         lit = in_disc;
      DYING:          lit = in_disc && !death_mouth;
      default:        lit = 1'b0;
    endcase
  end

endmodule

// File: rtl/pacman_sprite_animator.sv
// Pacman sprite animator: mouth cycle, death sequence, frame-latched orientation, registered pixel.
// Optional macro PACMAN_POWER_BLINK_EN adds the power-pill colour blink.
module pacman_sprite_animator
  import pacman_pkg::*;
#(
  parameter int         SPRITE_SIZE     = 16,
  parameter int         FRAMES_PER_STEP = 4,
  parameter int         DEATH_STEPS     = 8,
  parameter logic [7:0] SPRITE_COLOR    = `YELLOW
) (
  input  logic        clk,
  input  logic        resetN,
  input  logic [10:0] offset_x,
  input  logic [10:0] offset_y,
  input  logic        in_container,
  input  logic [1:0]  orientation,
  input  logic        moving,
  input  logic        frame_tick,
  input  logic        death_start,
  input  logic        revive,
  input  logic        power_blink,
  input  logic        dev_mode,
  output logic        dr_pm,
  output logic [7:0]  RGB_out,
  output logic        death_done,
  output logic [2:0]  anim_state
);

  localparam int          AW         = $clog2(SPRITE_SIZE);
  localparam logic [7:0]  LAST_STEP  = 8'(FRAMES_PER_STEP - 1);
  localparam logic [3:0]  LAST_DEATH = 4'(DEATH_STEPS - 1);
  localparam logic [10:0] SIZE11     = 11'(SPRITE_SIZE);

  anim_state_t   state;
  anim_state_t   next_state;
  logic [7:0]    step_cnt;
  logic [3:0]    death_idx;
  logic [1:0]    orient_q;
  logic [7:0]    rgb_q;
  logic          death_done_q;
  logic          mouth;
  logic          kill;
  logic          wake;
  logic          counting;
  logic          step_en;
  logic          last_death;

  assign mouth      = is_mouth_state(state);
  assign kill       = mouth && death_start;
  assign wake       = (state == DEAD) && revive;
  assign counting   = frame_tick && ((mouth && moving) || (state == DYING));
  assign step_en    = counting && (step_cnt == LAST_STEP);
  assign last_death = (state == DYING) && step_en && (death_idx == LAST_DEATH);

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) state <= OPEN;
    else         state <= next_state;
  end

  // death_start outranks a coincident step so the mouth never advances on the dying frame.
  always_comb begin
    next_state = state;
    if (kill) begin
      next_state = DYING;
    end else if (wake) begin
      next_state = OPEN;
    end else if (step_en) begin
      case (state)
        OPEN:    next_state = HALF_C;
        HALF_C:  next_state = CLOSED;
        CLOSED:  next_state = HALF_O;
        HALF_O:  next_state = OPEN;
        DYING:   next_state = last_death ? DEAD : DYING;
        default: next_state = state;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      step_cnt     <= '0;
      death_idx    <= '0;
      death_done_q <= 1'b0;
      orient_q     <= RIGHT;
    end else begin
      death_done_q <= last_death;
      if (frame_tick) orient_q <= orientation;
      if (kill || wake) begin
        step_cnt  <= '0;
        death_idx <= '0;
      end else if (counting) begin
        step_cnt <= step_en ? 8'd0 : step_cnt + 8'd1;
        if (step_en && (state == DYING) && !last_death) death_idx <= death_idx + 4'd1;
      end
    end
  end

  logic [AW-1:0] px;
  logic [AW-1:0] py;
  logic [AW-1:0] row;
  logic [AW-1:0] col;
  logic [1:0]    view;
  logic          in_range;
  logic          lit;
  logic          draw;
  logic [7:0]    color;

  assign px       = offset_x[AW-1:0];
  assign py       = offset_y[AW-1:0];
  assign in_range = in_container && (offset_x < SIZE11) && (offset_y < SIZE11);
  assign view     = (state == DYING) ? UP : orient_q;

  // Bitmaps face right; inverting an index gives N-1-index for a power-of-two edge.
  always_comb begin
    row = py;
    col = px;
    case (view)
      UP:      begin row = px; col = ~py; end
      DOWN:    begin row = px; col = py;  end
      LEFT:    begin row = py; col = ~px; end
      default: begin row = py; col = px;  end
    endcase
  end

  pacman_sprite_rom #(
    .SPRITE_SIZE (SPRITE_SIZE),
    .DEATH_STEPS (DEATH_STEPS)
  ) u_rom (
    .state     (state),
    .death_idx (death_idx),
    .row       (row),
    .col       (col),
    .lit       (lit)
  );

`ifdef PACMAN_POWER_BLINK_EN
  logic [3:0] blink_cnt;

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN)          blink_cnt <= '0;
    else if (!power_blink) blink_cnt <= '0;
    else if (frame_tick)  blink_cnt <= blink_cnt + 4'd1;
  end

  assign color = (power_blink && blink_cnt[3]) ? `WHITE : SPRITE_COLOR;
`else
  logic unused_blink;
  assign unused_blink = power_blink;
  assign color        = SPRITE_COLOR;
`endif

  assign draw = in_range && (state != DEAD) && (dev_mode || lit);

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) rgb_q <= `TRNS;
    else         rgb_q <= draw ? color : `TRNS;
  end

  assign RGB_out    = rgb_q;
  assign dr_pm      = (rgb_q != `TRNS);
  assign death_done = death_done_q;
  assign anim_state = state;

endmodule

// File: tb/tb_pacman_sprite_animator.sv
// Directed self-checking bench for pacman_sprite_animator (16-pixel sprite, 4 frames/step, 8 death steps).
// Blink expectations follow PACMAN_POWER_BLINK_EN when the bench is built with it.
module tb_pacman_sprite_animator;

  localparam logic [7:0] TRNS_C   = 8'h00;
  localparam logic [7:0] YELLOW_C = 8'hFC;
  localparam logic [7:0] WHITE_C  = 8'hFF;
`ifdef PACMAN_POWER_BLINK_EN
  localparam bit BLINK_EN = 1'b1;
`else
  localparam bit BLINK_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        resetN;
  logic [10:0] offset_x;
  logic [10:0] offset_y;
  logic        in_container;
  logic [1:0]  orientation;
  logic        moving;
  logic        frame_tick;
  logic        death_start;
  logic        revive;
  logic        power_blink;
  logic        dev_mode;
  logic        dr_pm;
  logic [7:0]  RGB_out;
  logic        death_done;
  logic [2:0]  anim_state;

  int errors = 0;
  int checks = 0;

  pacman_sprite_animator #(
    .SPRITE_SIZE     (16),
    .FRAMES_PER_STEP (4),
    .DEATH_STEPS     (8),
    .SPRITE_COLOR    (8'hFC)
  ) dut (
    .clk          (clk),
    .resetN       (resetN),
    .offset_x     (offset_x),
    .offset_y     (offset_y),
    .in_container (in_container),
    .orientation  (orientation),
    .moving       (moving),
    .frame_tick   (frame_tick),
    .death_start  (death_start),
    .revive       (revive),
    .power_blink  (power_blink),
    .dev_mode     (dev_mode),
    .dr_pm        (dr_pm),
    .RGB_out      (RGB_out),
    .death_done   (death_done),
    .anim_state   (anim_state)
  );

  always #5 clk = ~clk;

  task automatic idle_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic tick();
    frame_tick = 1'b1;
    @(posedge clk);
    #1;
    frame_tick = 1'b0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic set_pixel(input int x, input int y);
    offset_x     = 11'(x);
    offset_y     = 11'(y);
    in_container = 1'b1;
  endtask

  task automatic do_reset();
    resetN       = 1'b0;
    offset_x     = '0;
    offset_y     = '0;
    in_container = 1'b0;
    orientation  = 2'b11;
    moving       = 1'b0;
    frame_tick   = 1'b0;
    death_start  = 1'b0;
    revive       = 1'b0;
    power_blink  = 1'b0;
    dev_mode     = 1'b0;
    repeat (2) @(posedge clk);
    #1 resetN = 1'b1;
    idle_cycle();
  endtask

  task automatic test_reset();
    resetN = 1'b0; offset_x = '0; offset_y = '0; in_container = 1'b0;
    orientation = 2'b11; moving = 1'b0; frame_tick = 1'b0; death_start = 1'b0;
    revive = 1'b0; power_blink = 1'b0; dev_mode = 1'b0;
    #12;
    checks++; if (anim_state !== 3'd0) begin errors++; $display("FAIL reset_state: got %0d expected 0", anim_state); end
    checks++; if (RGB_out !== TRNS_C) begin errors++; $display("FAIL reset_rgb: got %0h expected %0h", RGB_out, TRNS_C); end
    checks++; if (dr_pm !== 1'b0) begin errors++; $display("FAIL reset_dr_pm: got %0b expected 0", dr_pm); end
    checks++; if (death_done !== 1'b0) begin errors++; $display("FAIL reset_death_done: got %0b expected 0", death_done); end
  endtask

  task automatic test_reset_mid_dying();
    do_reset();
    death_start = 1'b1;
    idle_cycle();
    death_start = 1'b0;
    checks++; if (anim_state !== 3'd4) begin errors++; $display("FAIL dying_entry: got %0d expected 4", anim_state); end
    ticks(12);
    set_pixel(8, 8);
    dev_mode = 1'b1;
    idle_cycle();
    checks++; if (anim_state !== 3'd4) begin errors++; $display("FAIL dying_idx3_state: got %0d expected 4", anim_state); end
    checks++; if (RGB_out !== YELLOW_C) begin errors++; $display("FAIL dying_dev_pixel: got %0h expected %0h", RGB_out, YELLOW_C); end
    #2 resetN = 1'b0;
    #1;
    checks++; if (anim_state !== 3'd0) begin errors++; $display("FAIL async_reset_state: got %0d expected 0", anim_state); end
    checks++; if (RGB_out !== TRNS_C) begin errors++; $display("FAIL async_reset_rgb: got %0h expected %0h", RGB_out, TRNS_C); end
    idle_cycle();
    checks++; if (death_done !== 1'b0) begin errors++; $display("FAIL reset_hold_death_done: got %0b expected 0", death_done); end
    checks++; if (anim_state !== 3'd0) begin errors++; $display("FAIL reset_hold_state: got %0d expected 0", anim_state); end
    resetN   = 1'b1;
    dev_mode = 1'b0;
    set_pixel(0, 8);
    idle_cycle();
    checks++; if (RGB_out !== YELLOW_C) begin errors++; $display("FAIL post_reset_pixel_0_8: got %0h expected %0h", RGB_out, YELLOW_C); end
    checks++; if (dr_pm !== 1'b1) begin errors++; $display("FAIL post_reset_dr_pm: got %0b expected 1", dr_pm); end
  endtask

  task automatic test_mouth_cycle();
    logic [2:0] exp_state;
    do_reset();
    moving = 1'b1;
    for (int t = 1; t <= 16; t++) begin
      tick();
      exp_state = 3'((t / 4) % 4);
      checks++;
      if (anim_state !== exp_state) begin errors++; $display("FAIL mouth_tick%0d: got %0d expected %0d", t, anim_state, exp_state); end
    end
    ticks(2);
    moving = 1'b0;
    ticks(40);
    checks++; if (anim_state !== 3'd0) begin errors++; $display("FAIL frozen_40_ticks: got %0d expected 0", anim_state); end
    moving = 1'b1;
    tick();
    checks++; if (anim_state !== 3'd0) begin errors++; $display("FAIL resume_tick3: got %0d expected 0", anim_state); end
    tick();
    checks++; if (anim_state !== 3'd1) begin errors++; $display("FAIL resume_tick4: got %0d expected 1", anim_state); end
  endtask

  task automatic test_orientation_latch();
    do_reset();
    set_pixel(15, 8);
    idle_cycle();
    checks++; if (RGB_out !== TRNS_C) begin errors++; $display("FAIL right_open_15_8: got %0h expected %0h", RGB_out, TRNS_C); end
    orientation = 2'b00;
    idle_cycle();
    idle_cycle();
    checks++; if (RGB_out !== TRNS_C) begin errors++; $display("FAIL orient_mid_frame: got %0h expected %0h", RGB_out, TRNS_C); end
    tick();
    idle_cycle();
    checks++; if (RGB_out !== YELLOW_C) begin errors++; $display("FAIL up_open_15_8: got %0h expected %0h", RGB_out, YELLOW_C); end
  endtask

  task automatic test_death();
    do_reset();
    moving = 1'b1;
    ticks(3);
    frame_tick  = 1'b1;
    death_start = 1'b1;
    @(posedge clk);
    #1;
    frame_tick  = 1'b0;
    death_start = 1'b0;
    checks++; if (anim_state !== 3'd4) begin errors++; $display("FAIL death_priority: got %0d expected 4", anim_state); end
    moving = 1'b0;
    ticks(31);
    checks++; if (anim_state !== 3'd4) begin errors++; $display("FAIL dying_tick31: got %0d expected 4", anim_state); end
    checks++; if (death_done !== 1'b0) begin errors++; $display("FAIL death_done_early: got %0b expected 0", death_done); end
    tick();
    checks++; if (anim_state !== 3'd5) begin errors++; $display("FAIL dead_tick32: got %0d expected 5", anim_state); end
    checks++; if (death_done !== 1'b1) begin errors++; $display("FAIL death_done_pulse: got %0b expected 1", death_done); end
    idle_cycle();
    checks++; if (death_done !== 1'b0) begin errors++; $display("FAIL death_done_width: got %0b expected 0", death_done); end
    set_pixel(8, 8);
    dev_mode = 1'b1;
    idle_cycle();
    checks++; if (RGB_out !== TRNS_C) begin errors++; $display("FAIL dead_transparent: got %0h expected %0h", RGB_out, TRNS_C); end
    checks++; if (dr_pm !== 1'b0) begin errors++; $display("FAIL dead_dr_pm: got %0b expected 0", dr_pm); end
    death_start = 1'b1;
    idle_cycle();
    death_start = 1'b0;
    checks++; if (anim_state !== 3'd5) begin errors++; $display("FAIL dead_ignores_start: got %0d expected 5", anim_state); end
    revive = 1'b1;
    idle_cycle();
    revive = 1'b0;
    checks++; if (anim_state !== 3'd0) begin errors++; $display("FAIL revive_open: got %0d expected 0", anim_state); end
    dev_mode = 1'b0;
    moving   = 1'b1;
    ticks(3);
    checks++; if (anim_state !== 3'd0) begin errors++; $display("FAIL revive_cnt_tick3: got %0d expected 0", anim_state); end
    tick();
    checks++; if (anim_state !== 3'd1) begin errors++; $display("FAIL revive_cnt_tick4: got %0d expected 1", anim_state); end
  endtask

  task automatic test_range_devmode();
    do_reset();
    set_pixel(16, 8);
    idle_cycle();
    checks++; if (RGB_out !== TRNS_C) begin errors++; $display("FAIL offset16_rgb: got %0h expected %0h", RGB_out, TRNS_C); end
    checks++; if (dr_pm !== 1'b0) begin errors++; $display("FAIL offset16_dr_pm: got %0b expected 0", dr_pm); end
    dev_mode = 1'b1;
    idle_cycle();
    checks++; if (RGB_out !== TRNS_C) begin errors++; $display("FAIL offset16_dev: got %0h expected %0h", RGB_out, TRNS_C); end
    set_pixel(0, 0);
    #1;
    checks++; if (RGB_out !== TRNS_C) begin errors++; $display("FAIL dev_latency: got %0h expected %0h", RGB_out, TRNS_C); end
    idle_cycle();
    checks++; if (RGB_out !== YELLOW_C) begin errors++; $display("FAIL dev_corner: got %0h expected %0h", RGB_out, YELLOW_C); end
    dev_mode = 1'b0;
    idle_cycle();
    checks++; if (RGB_out !== TRNS_C) begin errors++; $display("FAIL corner_outside_disc: got %0h expected %0h", RGB_out, TRNS_C); end
    set_pixel(2, 8);
    in_container = 1'b0;
    idle_cycle();
    checks++; if (RGB_out !== TRNS_C) begin errors++; $display("FAIL out_of_container: got %0h expected %0h", RGB_out, TRNS_C); end
  endtask

  task automatic test_power_blink();
    logic [7:0] exp_rgb;
    do_reset();
    set_pixel(2, 8);
    power_blink = 1'b1;
    idle_cycle();
    checks++; if (RGB_out !== YELLOW_C) begin errors++; $display("FAIL blink_tick0: got %0h expected %0h", RGB_out, YELLOW_C); end
    for (int t = 1; t < 16; t++) begin
      tick();
      idle_cycle();
      exp_rgb = (BLINK_EN && t >= 8) ? WHITE_C : YELLOW_C;
      checks++;
      if (RGB_out !== exp_rgb) begin errors++; $display("FAIL blink_tick%0d: got %0h expected %0h", t, RGB_out, exp_rgb); end
    end
    power_blink = 1'b0;
    idle_cycle();
    idle_cycle();
    checks++; if (RGB_out !== YELLOW_C) begin errors++; $display("FAIL blink_off: got %0h expected %0h", RGB_out, YELLOW_C); end
    power_blink = 1'b1;
    idle_cycle();
    idle_cycle();
    checks++; if (RGB_out !== YELLOW_C) begin errors++; $display("FAIL blink_cleared: got %0h expected %0h", RGB_out, YELLOW_C); end
  endtask

  initial begin
    test_reset();
    test_reset_mid_dying();
    test_mouth_cycle();
    test_orientation_latch();
    test_death();
    test_range_devmode();
    test_power_blink();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
